reg_file_wb: RTL and testbench

//   Multi-cycle CPU general register file: the consumer of the 5-bit destination-register select.

---
 rtl/reg_file_wb.sv | 83 ++++++++
 tb/tb_reg_file_wb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// reg_file_wb
//   General-purpose register file for a multi-cycle CPU. Holds 2**ADDR_W
//   registers of DATA_W bits. Register 0 always reads as zero.
//
//   Ports:
//     clk, rst      rising-edge clock, synchronous active-high reset
//     ra1 / rd1     read port 1 (rs), combinational
//     ra2 / rd2     read port 2 (rt), combinational
//     we, wa, wd    synchronous write port used in the WB state
//     dbg_a / dbg_d debug read port, combinational, never bypassed
//     wr_cnt        number of committed writes, saturating at 16'hFFFF
//
//   With BYPASS != 0, a read of the address being written in the current
//   cycle returns wd instead of the stored value.
module reg_file_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [15:0]       wr_cnt
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;
    logic              bypass_en;

    // A write to address 0 is discarded entirely: no storage, no count.
    assign commit    = we && (wa != '0);
    assign bypass_en = (BYPASS != 0) && commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs   <= '{default: '0};
            wr_cnt <= '0;
        end else if (commit) begin
            regs[wa] <= wd;
            if (wr_cnt != '1) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Bypass still applies while rst is high: reads reflect the current
    // cycle's inputs, the reset only takes effect at the edge.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (bypass_en && (ra1 == wa)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (bypass_en && (ra2 == wa)) begin
            rd2 = wd;
        end
    end

    always_comb begin
        dbg_d = regs[dbg_a];
        if (dbg_a == '0) begin
            dbg_d = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb
//   Scoreboard bench for reg_file_wb. Two instances share all inputs:
//   u_dut with BYPASS=1 and u_dut0 with BYPASS=0. Stimulus pushes the
//   expected outputs into a queue; the monitor pops and compares them on
//   the falling edge, while the inputs that produced them are still held.
module tb_reg_file_wb;

    localparam logic [5:0] M_R1   = 6'h01;
    localparam logic [5:0] M_R2   = 6'h02;
    localparam logic [5:0] M_DBG  = 6'h04;
    localparam logic [5:0] M_CNT  = 6'h08;
    localparam logic [5:0] M_R1B0 = 6'h10;
    localparam logic [5:0] M_R2B0 = 6'h20;

    typedef struct {
        string       name;
        logic [5:0]  mask;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
        logic [15:0] cnt;
        logic [31:0] r1b0;
        logic [31:0] r2b0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa, dbg_a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, dbg_d;
    logic [15:0] wr_cnt;
    logic [31:0] rd1_b0, rd2_b0, dbg_d_b0;
    logic [15:0] wr_cnt_b0;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_d), .wr_cnt(wr_cnt)
    );

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b0), .rd2(rd2_b0),
        .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_d_b0), .wr_cnt(wr_cnt_b0)
    );

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: the DUT presents its combinational outputs every cycle; any
    // expectations queued for this cycle are checked here.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.mask[0]) cmp(e.name, "rd1",    rd1,              e.r1);
            if (e.mask[1]) cmp(e.name, "rd2",    rd2,              e.r2);
            if (e.mask[2]) cmp(e.name, "dbg_d",  dbg_d,            e.dbg);
            if (e.mask[3]) cmp(e.name, "wr_cnt", {16'h0, wr_cnt},  {16'h0, e.cnt});
            if (e.mask[4]) cmp(e.name, "rd1_b0", rd1_b0,           e.r1b0);
            if (e.mask[5]) cmp(e.name, "rd2_b0", rd2_b0,           e.r2b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the current inputs, then advance one cycle.
    task automatic expect_step(input string name, input logic [5:0] mask,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] dbg, input logic [15:0] cnt,
                               input logic [31:0] r1b0, input logic [31:0] r2b0);
        exp_t e;
        e.name = name; e.mask = mask; e.r1 = r1; e.r2 = r2; e.dbg = dbg;
        e.cnt = cnt; e.r1b0 = r1b0; e.r2b0 = r2b0;
        q.push_back(e);
        step();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; dbg_a = '0;
        step(); step();
        rst = 1'b0;

        // Preload registers 1..31 with i * 0x01010101.
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h0101_0101);
        end
        ra1 = 5'd31; ra2 = 5'd4; dbg_a = 5'd7;
        expect_step("preload", M_R1 | M_R2 | M_DBG | M_CNT,
                    32'h1F1F_1F1F, 32'h0404_0404, 32'h0707_0707, 16'd31, '0, '0);

        // Test 1: plain reset clears everything.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); dbg_a = 5'(i);
            expect_step($sformatf("reset_clear[%0d]", i),
                        M_R1 | M_R2 | M_DBG | M_CNT | M_R1B0 | M_R2B0,
                        '0, '0, '0, 16'd0, '0, '0);
        end

        // Test 2: simple write then read.
        do_write(5'd5, 32'hDEAD_BEEF);
        ra1 = 5'd5; ra2 = 5'd5; dbg_a = 5'd5;
        expect_step("write5", M_R1 | M_R2 | M_DBG | M_CNT,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd1, '0, '0);

        // Test 3: writes to register 0 are ignored, and never bypassed.
        we = 1'b1; wa = 5'd0; wd = 32'h1234_5678;
        ra1 = 5'd0; ra2 = 5'd0; dbg_a = 5'd0;
        expect_step("r0_write_same_cycle", M_R1 | M_R2 | M_DBG | M_CNT | M_R1B0,
                    '0, '0, '0, 16'd1, '0, '0);
        we = 1'b0;
        expect_step("r0_after", M_R1 | M_R2 | M_DBG | M_CNT, '0, '0, '0, 16'd1, '0, '0);

        // Test 4: bypass on both ports, dbg never bypassed, BYPASS=0 sees old value.
        do_write(5'd7, 32'd1);
        we = 1'b1; wa = 5'd7; wd = 32'd2;
        ra1 = 5'd7; ra2 = 5'd7; dbg_a = 5'd7;
        expect_step("bypass_both", M_R1 | M_R2 | M_DBG | M_CNT | M_R1B0 | M_R2B0,
                    32'd2, 32'd2, 32'd1, 16'd2, 32'd1, 32'd1);
        we = 1'b0;
        expect_step("bypass_after", M_R1 | M_R2 | M_DBG | M_CNT | M_R1B0 | M_R2B0,
                    32'd2, 32'd2, 32'd2, 16'd3, 32'd2, 32'd2);
        // Bypass is per port: only the port matching wa is forwarded.
        we = 1'b1; wa = 5'd7; wd = 32'd3; ra1 = 5'd7; ra2 = 5'd5;
        expect_step("bypass_one_port", M_R1 | M_R2 | M_R1B0 | M_R2B0,
                    32'd3, 32'hDEAD_BEEF, '0, '0, 32'd2, 32'hDEAD_BEEF);
        we = 1'b0;

        // Back-to-back writes to one address keep the last value.
        do_write(5'd9, 32'hAAAA_0001);
        do_write(5'd9, 32'hBBBB_0002);
        ra1 = 5'd9; dbg_a = 5'd9;
        expect_step("consecutive", M_R1 | M_DBG | M_CNT,
                    32'hBBBB_0002, '0, 32'hBBBB_0002, 16'd6, '0, '0);

        // Test 5: write coincident with reset is dropped; bypass still applies that cycle.
        do_write(5'd3, 32'h33);
        rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'd9; ra1 = 5'd3; ra2 = 5'd9;
        expect_step("rst_cycle_read", M_R1 | M_R2 | M_CNT | M_R1B0,
                    32'd9, 32'hBBBB_0002, '0, 16'd7, 32'h33, '0);
        rst = 1'b0; we = 1'b0; dbg_a = 5'd3;
        expect_step("write_in_reset", M_R1 | M_R2 | M_DBG | M_CNT,
                    '0, '0, '0, 16'd0, '0, '0);

        // Test 6: saturation of wr_cnt.
        for (int i = 0; i < 65534; i++) begin
            do_write(5'd1, 32'(i));
        end
        ra1 = 5'd1;
        expect_step("cnt_fffe", M_R1 | M_CNT, 32'd65533, '0, '0, 16'hFFFE, '0, '0);
        do_write(5'd1, 32'h0001_0000);
        expect_step("cnt_ffff", M_CNT, '0, '0, '0, 16'hFFFF, '0, '0);
        do_write(5'd1, 32'hCAFE_0001);
        do_write(5'd1, 32'hCAFE_0002);
        dbg_a = 5'd1;
        expect_step("cnt_saturate", M_R1 | M_DBG | M_CNT,
                    32'hCAFE_0002, '0, 32'hCAFE_0002, 16'hFFFF, '0, '0);

        step();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
